// File: rtl/gate_model_tester.sv
// ---------------------------------------------------------------------------
// gate_model_tester
//   Sequential test driver for a combinational gate model. The driver applies
//   a pseudo-random LFSR stimulus sequence, waits SETTLE_CYCLES for the model
//   outputs to settle, and folds each captured response into a 16-bit MISR.
//   At the end of a run the signature is compared with a golden value.
//
// Ports
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous reset, active low (aborts a run)
//   start         in   1      run request, sampled only while idle
//   stim          out  IN_W   stimulus to the model (stim[0] -> N1)
//   resp          in   OUT_W  model outputs, resp[0] first
//   expected_sig  in   16     golden signature, sampled in DONE
//   busy          out  1      run in progress (SETTLE or CAPTURE)
//   done          out  1      one-cycle pulse at end of run
//   pass          out  1      signature matched, valid after done until next start
//   signature     out  16     MISR value, held after the run
//   pattern_idx   out  CW     patterns captured so far
// ---------------------------------------------------------------------------
module gate_model_tester #(
    parameter int              IN_W          = 15,
    parameter int              OUT_W         = 10,
    parameter int              PATTERN_COUNT = 256,
    parameter int              SETTLE_CYCLES = 2,
    parameter logic [IN_W-1:0] LFSR_SEED     = 15'h0001,
    localparam int             CW            = $clog2(PATTERN_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [IN_W-1:0]   stim,
    input  logic [OUT_W-1:0]  resp,
    input  logic [15:0]       expected_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       signature,
    output logic [CW-1:0]     pattern_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    // Settle counter only needs to reach SETTLE_CYCLES-1.
    localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]   LAST_IDX    = CW'(PATTERN_COUNT - 1);
    localparam bit              NO_SETTLE   = (SETTLE_CYCLES == 0);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [IN_W-1:0] SEED_EFF    = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

    state_t           state_q;
    logic [IN_W-1:0]  stim_q;
    logic [IN_W-1:0]  stim_d;
    logic [15:0]      sig_q;
    logic [15:0]      sig_d;
    logic [CW-1:0]    idx_q;
    logic [SW-1:0]    settle_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    // Next LFSR state (x^15 + x^14 + 1) and next MISR state for the current response.
    assign stim_d = {stim_q[IN_W-2:0], stim_q[IN_W-1] ^ stim_q[IN_W-2]};
    assign sig_d  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(resp);

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stim_q   <= '0;
            sig_q    <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        stim_q   <= SEED_EFF;
                        sig_q    <= '0;
                        idx_q    <= '0;
                        settle_q <= '0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        if (NO_SETTLE) state_q <= CAPTURE;
                        else           state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_q <= settle_q + 1'b1;
                    if (settle_q == SETTLE_LAST) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    sig_q    <= sig_d;
                    stim_q   <= stim_d;
                    idx_q    <= idx_q + 1'b1;
                    settle_q <= '0;
                    if (idx_q == LAST_IDX) begin
                        // done is raised while the FSM sits in DONE.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (NO_SETTLE) begin
                        state_q <= CAPTURE;
                    end else begin
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    pass_q  <= (sig_q == expected_sig);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim        = stim_q;
    assign signature   = sig_q;
    assign pattern_idx = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_gate_model_tester.sv
// ---------------------------------------------------------------------------
// tb_gate_model_tester
//   Drives randomized runs of gate_model_tester against a behavioural gate
//   model. A reference model predicts every capture and the end-of-run result
//   into queues; a negedge monitor pops and compares whenever the DUT shows a
//   capture (pattern_idx advances) or the done pulse.
// ---------------------------------------------------------------------------
module tb_gate_model_tester;

    localparam int IN_W  = 15;
    localparam int OUT_W = 10;
    localparam int PC    = 8;
    localparam int SC    = 2;
    localparam int CW    = $clog2(PC + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IN_W-1:0]   stim;
    logic [OUT_W-1:0]  resp;
    logic [15:0]       expected_sig = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       signature;
    logic [CW-1:0]     pattern_idx;

    int                resp_mode = 0;       // 0: constant response, 1: gate function
    logic [OUT_W-1:0]  resp_const = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IN_W-1:0] stim_after;
        logic [15:0]     sig;
        int              idx;
    } cap_t;

    typedef struct {
        logic [15:0] sig;
        bit          pass;
    } res_t;

    cap_t cap_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    // Seed 0 exercises the zero-seed replacement.
    gate_model_tester #(
        .IN_W          (IN_W),
        .OUT_W         (OUT_W),
        .PATTERN_COUNT (PC),
        .SETTLE_CYCLES (SC),
        .LFSR_SEED     (15'h0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stim         (stim),
        .resp         (resp),
        .expected_sig (expected_sig),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .pattern_idx  (pattern_idx)
    );

    // Behavioural stand-in for a combinational gate model.
    function automatic logic [OUT_W-1:0] gate_fn(input logic [IN_W-1:0] s);
        logic [OUT_W-1:0] r;
        for (int i = 0; i < OUT_W; i++)
            r[i] = (s[i] & s[(i + 3) % IN_W]) ^ s[(i + 7) % IN_W] ^ (s[(i + 11) % IN_W] | s[IN_W - 1 - i]);
        return r;
    endfunction

    assign resp = (resp_mode == 0) ? resp_const : gate_fn(stim);

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    // Polynomial form: shift into bit 16, reduce by x^16+x^12+x^5+1, add response.
    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [OUT_W-1:0] r);
        logic [16:0] t;
        t = {m, 1'b0};
        if (t[16]) t = t ^ 17'h11021;
        return t[15:0] ^ {6'b0, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict a whole run and set the golden signature (optionally corrupted).
    task automatic predict(input bit flip);
        logic [IN_W-1:0]  s;
        logic [15:0]      m;
        logic [OUT_W-1:0] r;
        s = 15'h0001;
        m = '0;
        for (int k = 0; k < PC; k++) begin
            r = (resp_mode == 0) ? resp_const : gate_fn(s);
            m = misr_step(m, r);
            s = lfsr_step(s);
            cap_q.push_back('{s, m, k + 1});
        end
        expected_sig = flip ? (m ^ 16'h0040) : m;
        res_q.push_back('{m, !flip});
    endtask

    task automatic run(input bit flip, input bit poke);
        int n;
        predict(flip);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pass_cleared_on_start", pass, 0);
        check("busy_after_start", busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (poke) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("done_timeout", done, 1);
        // start held through the DONE cycle must not launch a new run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", busy, 0);
        @(negedge clk);
    endtask

    // Scoreboard monitor.
    logic [CW-1:0] prev_idx = '0;
    int            busy_cnt = 0;
    bit            pend = 1'b0;
    bit            pend_pass = 1'b0;

    always @(negedge clk) begin
        cap_t c;
        res_t r;
        if (!rst_n) begin
            prev_idx = '0;
            busy_cnt = 0;
            pend     = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (pattern_idx != prev_idx && pattern_idx != '0) begin
                if (cap_q.size() == 0) begin
                    check("unexpected_capture", cap_q.size(), 1);
                end else begin
                    c = cap_q.pop_front();
                    check("pattern_idx", pattern_idx, c.idx);
                    check("signature", signature, c.sig);
                    check("stim", stim, c.stim_after);
                end
            end
            prev_idx = pattern_idx;
            if (pend) begin
                check("pass", pass, pend_pass);
                pend = 1'b0;
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", res_q.size(), 1);
                end else begin
                    r = res_q.pop_front();
                    check("final_signature", signature, r.sig);
                    check("busy_during_done", busy, 0);
                    check("run_length", busy_cnt, PC * (SC + 1));
                    pend      = 1'b1;
                    pend_pass = r.pass;
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_stim", stim, 0);
        check("reset_signature", signature, 0);
        check("reset_pattern_idx", pattern_idx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero response, golden 0 -> signature 0, pass.
        resp_mode  = 0;
        resp_const = '0;
        run(1'b0, 1'b0);
        check("zero_resp_sig", signature, 16'h0000);

        // Constant response 1: signature doubles-plus-one each pattern.
        resp_const = 10'h001;
        run(1'b0, 1'b0);
        check("const1_sig", signature, 16'h00FF);
        check("stim_after_run", stim, 15'h0100);
        run(1'b1, 1'b0);

        // Gate function, with start pokes while busy.
        resp_mode = 1;
        run(1'b0, 1'b1);
        run(1'b1, 1'b1);

        // Asynchronous abort during the second SETTLE phase.
        resp_mode  = 0;
        resp_const = 10'h001;
        predict(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (pattern_idx != CW'(1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("abort_wait_timeout", pattern_idx, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_stim", stim, 0);
        check("abort_signature", signature, 0);
        check("abort_pattern_idx", pattern_idx, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        cap_q.delete();
        res_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, 1'b0);
        check("clean_run_sig", signature, 16'h00FF);

        // Randomized runs.
        for (int i = 0; i < 6; i++) begin
            resp_mode  = int'($urandom_range(0, 1));
            resp_const = OUT_W'($urandom);
            run(1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", cap_q.size() + res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
